// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Request/acknowledge instruction-memory port between the fetch stage and
//   the instruction memory.
//   Signals:
//     imem_req    fetch request (fetch unit -> memory)
//     imem_addr   32-bit word address, held stable while imem_req waits for ack
//     imem_rdata  32-bit fetched word, valid when imem_ack is high
//     imem_ack    single-cycle completion pulse, may arrive in the first req cycle
//   Modports:
//     master  the fetch unit side
//     slave   the instruction memory side
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage; producer side of the IF/ID pipeline register.
//   Holds the PC, fetches words over a req/ack memory port, stages each word
//   in a one-entry buffer, and applies stalls and branch/jump redirects,
//   including redirects that land while a memory access is outstanding.
//
//   Parameters:
//     RESET_PC     PC value after reset
//     PC_INC       PC increment per instruction (word addressing)
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     imem         fetch_unit_if.master instruction-memory port
//     stall        hazard unit: IF/ID must not load this cycle
//     redirect     taken branch/jump pulse, redirect_pc is its target
//     inst, add1   buffered instruction and its address + PC_INC, to IF/ID
//     if_id_ld     IF/ID load enable
//     if_id_flsh   IF/ID flush (follows redirect combinationally)
//     pc           current fetch PC
//   Optional build macro:
//     FETCH_PERF_CNT_EN  adds perf_fetched / perf_flushed 32-bit counters
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  fetch_unit_if.master imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] add1,
  output logic        if_id_ld,
  output logic        if_id_flsh,
  output logic [31:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_add1_q, buf_add1_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        req_pending_q, req_pending_d;

  logic        req;
  logic        ack;
  logic [31:0] addr;

  // Request and handshake outputs. Both IF/ID load and the memory request
  // are held low while rst is high, so the first request appears in the
  // cycle after rst falls. A request already raised keeps req_pending set,
  // which holds it up even if the buffer would otherwise block it.
  assign if_id_ld   = !rst && buf_valid_q && !stall && !redirect;
  assign if_id_flsh = redirect;
  assign req        = !rst && ((state_q == DRAIN) ||
                               (!buf_valid_q || if_id_ld || req_pending_q));
  assign addr       = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign ack        = req && imem.imem_ack;

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;
  assign inst           = buf_inst_q;
  assign add1           = buf_add1_q;
  assign pc             = pc_q;

  // Next-state logic for the PC, the one-entry buffer and the FETCH/DRAIN
  // FSM. Redirect wins over ack and stall. A redirect that leaves a request
  // unanswered parks its address in drain_addr so the memory sees a stable
  // request until it acks; that returned word is then thrown away.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_inst_d    = buf_inst_q;
    buf_add1_d    = buf_add1_q;
    buf_valid_d   = buf_valid_q;
    drain_addr_d  = drain_addr_q;
    req_pending_d = req_pending_q;

    if (ack) begin
      req_pending_d = 1'b0;
    end else if (req) begin
      req_pending_d = 1'b1;
    end

    case (state_q)
      FETCH: begin
        if (redirect) begin
          buf_valid_d = 1'b0;
          pc_d        = redirect_pc;
          if (req && !ack) begin
            drain_addr_d = addr;
            state_d      = DRAIN;
          end
        end else if (ack) begin
          // Same-edge drain and refill when if_id_ld is also high.
          buf_inst_d  = imem.imem_rdata;
          buf_add1_d  = pc_q + PC_INC;
          buf_valid_d = 1'b1;
          pc_d        = pc_q + PC_INC;
        end else if (if_id_ld) begin
          buf_valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (redirect) begin
          buf_valid_d = 1'b0;
          pc_d        = redirect_pc;
        end
        if (ack) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      buf_inst_q    <= 32'h0;
      buf_add1_q    <= 32'h0;
      buf_valid_q   <= 1'b0;
      drain_addr_q  <= 32'h0;
      req_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf_inst_q    <= buf_inst_d;
      buf_add1_q    <= buf_add1_d;
      buf_valid_q   <= buf_valid_d;
      drain_addr_q  <= drain_addr_d;
      req_pending_q <= req_pending_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  // Delivered-instruction and flush counters, wrapping at 2^32.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_flushed_d = perf_flushed_q;
    if (if_id_ld) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (redirect) begin
      perf_flushed_d = perf_flushed_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'h0;
      perf_flushed_q <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed bench for fetch_unit. A small memory responder acks each
//   request after ack_delay cycles and returns addr ^ 32'hA5A5_0000.
//   Expected values below are hand-computed per cycle.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] add1;
  logic        if_id_ld;
  logic        if_id_flsh;
  logic [31:0] pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int ack_delay   = 0;
  int wait_cnt    = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .add1        (add1),
    .if_id_ld    (if_id_ld),
    .if_id_flsh  (if_id_flsh),
    .pc          (pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Memory responder: ack once the request has waited ack_delay cycles.
  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= ack_delay);
  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

  // Wait counter for the responder; shares rst with the fetch unit.
  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ack) begin
      wait_cnt <= 0;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge and let them settle.
  task automatic applyStimulus(input logic r, input logic s, input logic rd,
                               input logic [31:0] rpc, input int dly);
    @(negedge clk);
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    ack_delay   = dly;
    #1;
  endtask

  initial begin
    logic [31:0] exp_word;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("reset_pc",   pc, 32'h0);
    checkOutput("reset_ld",   32'(if_id_ld), 32'h0);
    checkOutput("reset_req",  32'(bus.imem_req), 32'h0);
    checkOutput("reset_inst", inst, 32'h0);
    checkOutput("reset_add1", add1, 32'h0);
    checkOutput("reset_flsh", 32'(if_id_flsh), 32'h0);

    // First request right after reset, zero-wait memory
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("first_req",  32'(bus.imem_req), 32'h1);
    checkOutput("first_addr", bus.imem_addr, 32'h0);
    checkOutput("first_ld",   32'(if_id_ld), 32'h0);

    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
      exp_word = 32'(k - 1) ^ 32'hA5A5_0000;
      checkOutput("stream_ld",   32'(if_id_ld), 32'h1);
      checkOutput("stream_add1", add1, 32'(k));
      checkOutput("stream_inst", inst, exp_word);
    end

    // Stall three cycles with the buffer full (word 4 held)
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 0);
      checkOutput("stall_ld",   32'(if_id_ld), 32'h0);
      checkOutput("stall_req",  32'(bus.imem_req), 32'h0);
      checkOutput("stall_add1", add1, 32'h5);
      checkOutput("stall_inst", inst, 32'hA5A5_0004);
    end

    // Stall falls: delivery resumes, request for 5 waits 3 cycles
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 3);
    checkOutput("resume_ld",   32'(if_id_ld), 32'h1);
    checkOutput("resume_add1", add1, 32'h5);
    checkOutput("resume_req",  32'(bus.imem_req), 32'h1);
    checkOutput("resume_addr", bus.imem_addr, 32'h5);

    // Redirect to 0x80 while the request for 5 is outstanding
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80, 3);
    checkOutput("rdr80_flsh", 32'(if_id_flsh), 32'h1);
    checkOutput("rdr80_ld",   32'(if_id_ld), 32'h0);
    checkOutput("rdr80_addr", bus.imem_addr, 32'h5);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 3);
    checkOutput("drain_req",  32'(bus.imem_req), 32'h1);
    checkOutput("drain_addr", bus.imem_addr, 32'h5);
    checkOutput("drain_pc",   pc, 32'h80);
    checkOutput("drain_flsh", 32'(if_id_flsh), 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 3);
    checkOutput("drain_ack_addr", bus.imem_addr, 32'h5);
    checkOutput("drain_ack_ld",   32'(if_id_ld), 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("after_drain_addr", bus.imem_addr, 32'h80);
    checkOutput("after_drain_ld",   32'(if_id_ld), 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("tgt80_ld",   32'(if_id_ld), 32'h1);
    checkOutput("tgt80_add1", add1, 32'h81);
    checkOutput("tgt80_inst", inst, 32'hA5A5_0080);

    // Buffer full under stall, then redirect to 0x40 with nothing outstanding
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 0);
    checkOutput("full_ld",   32'(if_id_ld), 32'h0);
    checkOutput("full_req",  32'(bus.imem_req), 32'h0);
    checkOutput("full_add1", add1, 32'h82);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 0);
    checkOutput("rdr40_flsh", 32'(if_id_flsh), 32'h1);
    checkOutput("rdr40_ld",   32'(if_id_ld), 32'h0);
    checkOutput("rdr40_req",  32'(bus.imem_req), 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("rdr40_next_req",  32'(bus.imem_req), 32'h1);
    checkOutput("rdr40_next_addr", bus.imem_addr, 32'h40);
    checkOutput("rdr40_empty_ld",  32'(if_id_ld), 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("tgt40_ld",   32'(if_id_ld), 32'h1);
    checkOutput("tgt40_add1", add1, 32'h41);
    checkOutput("tgt40_inst", inst, 32'hA5A5_0040);

    // Enter DRAIN, then reset in the middle of it
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5);
    checkOutput("pre_drain_ld",   32'(if_id_ld), 32'h1);
    checkOutput("pre_drain_add1", add1, 32'h42);
    checkOutput("pre_drain_addr", bus.imem_addr, 32'h42);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 5);
    checkOutput("rdr100_flsh", 32'(if_id_flsh), 32'h1);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 5);
    checkOutput("drain2_addr", bus.imem_addr, 32'h42);
    checkOutput("drain2_pc",   pc, 32'h100);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 5);
    checkOutput("rst_drain_req", 32'(bus.imem_req), 32'h0);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("rst2_pc",   pc, 32'h0);
    checkOutput("rst2_ld",   32'(if_id_ld), 32'h0);
    checkOutput("rst2_req",  32'(bus.imem_req), 32'h0);
    checkOutput("rst2_inst", inst, 32'h0);
    checkOutput("rst2_add1", add1, 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("rst2_first_req",  32'(bus.imem_req), 32'h1);
    checkOutput("rst2_first_addr", bus.imem_addr, 32'h0);

    // Ten back-to-back deliveries, then two redirects
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
      checkOutput("run_ld",   32'(if_id_ld), 32'h1);
      checkOutput("run_add1", add1, 32'(k));
    end

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 0);
    checkOutput("rdr200_flsh", 32'(if_id_flsh), 32'h1);
    checkOutput("rdr200_ld",   32'(if_id_ld), 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("rdr200_addr", bus.imem_addr, 32'h200);
    checkOutput("rdr200_ld2",  32'(if_id_ld), 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h300, 0);
    checkOutput("rdr300_flsh", 32'(if_id_flsh), 32'h1);
    checkOutput("rdr300_ld",   32'(if_id_ld), 32'h0);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 0);
    checkOutput("rdr300_addr", bus.imem_addr, 32'h300);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_fetched", perf_fetched, 32'd10);
    checkOutput("perf_flushed", perf_flushed, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
